if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 90 +++++++++
 tb/tb_if_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: drives the instruction SRAM request for next_pc and
// presents the fetched instruction to ID, buffering it while ID stalls.
module if_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        id_allow_in,
    input  logic [32:0] id_to_if_branch_bus,
    output logic [64:0] if_to_id_instruction_bus,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_wen,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata
);

    localparam logic [31:0] RESET_PC = 32'hBFBF_FFFC;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } branch_bus_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] program_count;
        logic [31:0] instruction;
    } inst_bus_t;

    branch_bus_t branch;
    inst_bus_t   out_bus;

    logic        if_valid;
    logic [31:0] if_pc;
    logic        buf_valid;
    logic [31:0] buf_inst;

    logic        if_ready_go;
    logic        if_allow_in;
    logic [31:0] seq_pc;
    logic [31:0] next_pc;

    assign branch = id_to_if_branch_bus;

    assign if_ready_go = 1'b1;
    assign if_allow_in = !if_valid || (if_ready_go && id_allow_in);
    assign seq_pc      = if_pc + 32'd4;

    // A taken branch only redirects when a delay-slot instruction sits in IF;
    // ID keeps taken asserted until its branch moves on, so nothing is latched.
    assign next_pc = (branch.taken && if_valid) ? branch.target : seq_pc;

    assign inst_sram_en    = if_allow_in;
    assign inst_sram_addr  = next_pc;
    assign inst_sram_wen   = 4'h0;
    assign inst_sram_wdata = 32'h0;

    always_ff @(posedge clock) begin
        if (reset) begin
            if_valid <= 1'b0;
            if_pc    <= RESET_PC;
        end else if (if_allow_in) begin
            if_valid <= 1'b1;
            if_pc    <= next_pc;
        end
    end

    // SRAM data is only valid the cycle after the request, so capture it on the
    // first stall cycle and replay it until ID accepts.
    always_ff @(posedge clock) begin
        if (reset) begin
            buf_valid <= 1'b0;
            buf_inst  <= 32'h0;
        end else if (id_allow_in) begin
            buf_valid <= 1'b0;
        end else if (if_valid && !buf_valid) begin
            buf_valid <= 1'b1;
            buf_inst  <= inst_sram_rdata;
        end
    end

    always_comb begin
        out_bus               = '0;
        out_bus.valid         = if_valid;
        out_bus.program_count = if_pc;
        out_bus.instruction   = buf_valid ? buf_inst : inst_sram_rdata;
    end

    assign if_to_id_instruction_bus = out_bus;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a one-cycle-latency SRAM model returning
// address-tagged data (garbage when not enabled).
module tb_if_stage;

    logic        clock;
    logic        reset;
    logic        id_allow_in;
    logic [32:0] id_to_if_branch_bus;
    logic [64:0] if_to_id_instruction_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;

    int total = 0;
    int bad   = 0;

    logic        taken;
    logic [31:0] target;
    logic        bus_valid;
    logic [31:0] bus_pc;
    logic [31:0] bus_inst;

    assign id_to_if_branch_bus = {taken, target};
    assign bus_valid = if_to_id_instruction_bus[64];
    assign bus_pc    = if_to_id_instruction_bus[63:32];
    assign bus_inst  = if_to_id_instruction_bus[31:0];

    if_stage dut (
        .clock                    (clock),
        .reset                    (reset),
        .id_allow_in              (id_allow_in),
        .id_to_if_branch_bus      (id_to_if_branch_bus),
        .if_to_id_instruction_bus (if_to_id_instruction_bus),
        .inst_sram_en             (inst_sram_en),
        .inst_sram_wen            (inst_sram_wen),
        .inst_sram_addr           (inst_sram_addr),
        .inst_sram_wdata          (inst_sram_wdata),
        .inst_sram_rdata          (inst_sram_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h1234_5678;
    endfunction

    initial inst_sram_rdata = 32'h0;
    always @(posedge clock) begin
        if (inst_sram_en) inst_sram_rdata <= inst_of(inst_sram_addr);
        else              inst_sram_rdata <= $urandom;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; id_allow_in = 1'b1; taken = 1'b0; target = 32'h0;
        tick(); tick();
        total++;
        if (bus_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus_valid); end
        reset = 1'b0;
        #1;
        total++;
        if (inst_sram_en !== 1'b1) begin bad++; $display("FAIL reset_en got=%b exp=1", inst_sram_en); end
        total++;
        if (inst_sram_addr !== 32'hBFC0_0000) begin bad++; $display("FAIL reset_addr got=%h exp=bfc00000", inst_sram_addr); end
        total++;
        if (inst_sram_wen !== 4'h0 || inst_sram_wdata !== 32'h0) begin
            bad++; $display("FAIL tie_off got wen=%h wdata=%h exp 0/0", inst_sram_wen, inst_sram_wdata);
        end
    endtask

    task automatic test_seq_fetch();
        logic [31:0] pc;
        for (int i = 0; i < 3; i++) begin
            pc = 32'hBFC0_0000 + 32'(4 * i);
            tick();
            total++;
            if (bus_valid !== 1'b1 || bus_pc !== pc || bus_inst !== inst_of(pc)) begin
                bad++; $display("FAIL seq_bus got v=%b pc=%h inst=%h exp v=1 pc=%h inst=%h",
                                bus_valid, bus_pc, bus_inst, pc, inst_of(pc));
            end
            total++;
            if (inst_sram_en !== 1'b1 || inst_sram_addr !== pc + 32'd4) begin
                bad++; $display("FAIL seq_addr got en=%b addr=%h exp en=1 addr=%h",
                                inst_sram_en, inst_sram_addr, pc + 32'd4);
            end
        end
    endtask

    task automatic test_stall();
        id_allow_in = 1'b0;
        #1;
        total++;
        if (inst_sram_en !== 1'b0) begin bad++; $display("FAIL stall_en got=%b exp=0", inst_sram_en); end
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (bus_valid !== 1'b1 || bus_pc !== 32'hBFC0_0008 || bus_inst !== inst_of(32'hBFC0_0008)) begin
                bad++; $display("FAIL stall_bus got v=%b pc=%h inst=%h exp v=1 pc=bfc00008 inst=%h",
                                bus_valid, bus_pc, bus_inst, inst_of(32'hBFC0_0008));
            end
            total++;
            if (inst_sram_en !== 1'b0) begin bad++; $display("FAIL stall_en_hold got=%b exp=0", inst_sram_en); end
        end
        id_allow_in = 1'b1;
        #1;
        total++;
        if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'hBFC0_000C) begin
            bad++; $display("FAIL resume_addr got en=%b addr=%h exp en=1 addr=bfc0000c", inst_sram_en, inst_sram_addr);
        end
        total++;
        if (bus_inst !== inst_of(32'hBFC0_0008)) begin
            bad++; $display("FAIL resume_inst got=%h exp=%h", bus_inst, inst_of(32'hBFC0_0008));
        end
        tick();
        total++;
        if (bus_pc !== 32'hBFC0_000C || bus_inst !== inst_of(32'hBFC0_000C)) begin
            bad++; $display("FAIL after_stall got pc=%h inst=%h exp pc=bfc0000c inst=%h",
                            bus_pc, bus_inst, inst_of(32'hBFC0_000C));
        end
    endtask

    task automatic test_branch();
        tick();
        taken = 1'b1; target = 32'hBFC0_0100;
        #1;
        total++;
        if (inst_sram_addr !== 32'hBFC0_0100 || bus_pc !== 32'hBFC0_0010 || bus_inst !== inst_of(32'hBFC0_0010)) begin
            bad++; $display("FAIL branch_redirect got addr=%h pc=%h inst=%h exp addr=bfc00100 pc=bfc00010 inst=%h",
                            inst_sram_addr, bus_pc, bus_inst, inst_of(32'hBFC0_0010));
        end
        tick();
        taken = 1'b0;
        #1;
        total++;
        if (bus_pc !== 32'hBFC0_0100 || bus_inst !== inst_of(32'hBFC0_0100) || inst_sram_addr !== 32'hBFC0_0104) begin
            bad++; $display("FAIL branch_target got pc=%h inst=%h addr=%h exp pc=bfc00100 inst=%h addr=bfc00104",
                            bus_pc, bus_inst, inst_sram_addr, inst_of(32'hBFC0_0100));
        end
    endtask

    task automatic test_branch_stall();
        tick();
        taken = 1'b1; target = 32'hBFC0_0200; id_allow_in = 1'b0;
        #1;
        total++;
        if (inst_sram_en !== 1'b0) begin bad++; $display("FAIL bstall_en got=%b exp=0", inst_sram_en); end
        tick();
        target = 32'hBFC0_0300;
        #1;
        total++;
        if (bus_pc !== 32'hBFC0_0104 || bus_inst !== inst_of(32'hBFC0_0104) || inst_sram_en !== 1'b0) begin
            bad++; $display("FAIL bstall_hold got pc=%h inst=%h en=%b exp pc=bfc00104 inst=%h en=0",
                            bus_pc, bus_inst, inst_sram_en, inst_of(32'hBFC0_0104));
        end
        tick();
        target = 32'hBFC0_0400; id_allow_in = 1'b1;
        #1;
        total++;
        if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'hBFC0_0400) begin
            bad++; $display("FAIL bstall_release got en=%b addr=%h exp en=1 addr=bfc00400", inst_sram_en, inst_sram_addr);
        end
        tick();
        taken = 1'b0;
        #1;
        total++;
        if (bus_pc !== 32'hBFC0_0400 || bus_inst !== inst_of(32'hBFC0_0400)) begin
            bad++; $display("FAIL bstall_target got pc=%h inst=%h exp pc=bfc00400 inst=%h",
                            bus_pc, bus_inst, inst_of(32'hBFC0_0400));
        end
    endtask

    task automatic test_ignore_taken();
        reset = 1'b1; taken = 1'b1; target = 32'hDEAD_0000;
        tick(); tick();
        total++;
        if (bus_valid !== 1'b0) begin bad++; $display("FAIL rereset_valid got=%b exp=0", bus_valid); end
        reset = 1'b0;
        #1;
        total++;
        if (inst_sram_addr !== 32'hBFC0_0000 || inst_sram_en !== 1'b1) begin
            bad++; $display("FAIL ignore_taken got en=%b addr=%h exp en=1 addr=bfc00000", inst_sram_en, inst_sram_addr);
        end
        tick();
        taken = 1'b0;
        #1;
        total++;
        if (bus_valid !== 1'b1 || bus_pc !== 32'hBFC0_0000 || bus_inst !== inst_of(32'hBFC0_0000)) begin
            bad++; $display("FAIL ignore_taken_bus got v=%b pc=%h inst=%h exp v=1 pc=bfc00000 inst=%h",
                            bus_valid, bus_pc, bus_inst, inst_of(32'hBFC0_0000));
        end
    endtask

    task automatic test_wrap();
        taken = 1'b1; target = 32'hFFFF_FFFC;
        #1;
        tick();
        taken = 1'b0;
        #1;
        total++;
        if (bus_pc !== 32'hFFFF_FFFC || inst_sram_addr !== 32'h0000_0000) begin
            bad++; $display("FAIL wrap_addr got pc=%h addr=%h exp pc=fffffffc addr=00000000", bus_pc, inst_sram_addr);
        end
        tick();
        total++;
        if (bus_pc !== 32'h0000_0000 || bus_inst !== inst_of(32'h0000_0000) || inst_sram_addr !== 32'h0000_0004) begin
            bad++; $display("FAIL wrap_bus got pc=%h inst=%h addr=%h exp pc=00000000 inst=%h addr=00000004",
                            bus_pc, bus_inst, inst_sram_addr, inst_of(32'h0000_0000));
        end
    endtask

    initial begin
        test_reset();
        test_seq_fetch();
        test_stall();
        test_branch();
        test_branch_stall();
        test_ignore_taken();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
